writeback_stage: RTL and testbench

//  Parametrised M->W pipeline register plus writeback result select for the pipelined RV core.

---
 rtl/writeback_stage.sv | 140 ++++++++++++++
 tb/tb_writeback_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// M->W pipeline register with writeback result select, load extraction,
// x0 write suppression and a retired-instruction counter.
module writeback_stage #(
  parameter  int XLEN    = 32,
  parameter  int NUM_SRC = 4,
  parameter  int CNT_W   = 64,
  localparam int SEL_W   = $clog2(NUM_SRC),
  localparam int LSB_W   = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_w,
  input  logic             flush_w,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic [SEL_W-1:0] result_src_m,
  input  logic [2:0]       load_type_m,
  input  logic [LSB_W-1:0] addr_lsb_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus_4m,
  input  logic [XLEN-1:0]  imm_ext_m,
  output logic             valid_w,
  output logic             reg_write_w,
  output logic [4:0]       rd_w,
  output logic [XLEN-1:0]  result_w,
  output logic             misalign_w,
  output logic [CNT_W-1:0] instret
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [4:0]       rd;
    logic [SEL_W-1:0] src;
    logic [2:0]       load_type;
    logic [LSB_W-1:0] lsb;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  rdata;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  imm;
  } w_t;

  w_t               w_d, w_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  logic [XLEN-1:0]  sh;
  logic [XLEN-1:0]  load_val;
  logic             aligned;
  logic             misalign;

  always_comb begin
    w_d = w_q;
    if (flush_w) begin
      w_d.valid     = 1'b0;
      w_d.reg_write = 1'b0;
    end else if (!stall_w) begin
      w_d.valid     = valid_m;
      w_d.reg_write = reg_write_m;
      w_d.rd        = rd_m;
      w_d.src       = result_src_m;
      w_d.load_type = load_type_m;
      w_d.lsb       = addr_lsb_m;
      w_d.alu       = alu_result_m;
      w_d.rdata     = read_data_m;
      w_d.pc4       = pc_plus_4m;
      w_d.imm       = imm_ext_m;
    end
    // An instruction is counted on the edge where it leaves W.
    instret_d = instret_q + CNT_W'(w_q.valid & ~stall_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      instret_q <= '0;
    end else begin
      w_q       <= w_d;
      instret_q <= instret_d;
    end
  end

  // Illegal load types leave load_val as the raw word and aligned=1.
  always_comb begin
    sh       = w_q.rdata >> {w_q.lsb, 3'b000};
    load_val = w_q.rdata;
    aligned  = 1'b1;
    case (w_q.load_type)
      3'b000: load_val = XLEN'($signed(sh[7:0]));
      3'b001: begin
        load_val = XLEN'($signed(sh[15:0]));
        aligned  = ~w_q.lsb[0];
      end
      3'b010: begin
        load_val = XLEN'($signed(sh[31:0]));
        aligned  = (w_q.lsb[1:0] == 2'b00);
      end
      3'b100: load_val = XLEN'(sh[7:0]);
      3'b101: begin
        load_val = XLEN'(sh[15:0]);
        aligned  = ~w_q.lsb[0];
      end
      3'b110: begin
        if (XLEN == 64) begin
          load_val = XLEN'(sh[31:0]);
          aligned  = (w_q.lsb[1:0] == 2'b00);
        end
      end
      3'b011: begin
        if (XLEN == 64) begin
          load_val = sh;
          aligned  = (w_q.lsb == '0);
        end
      end
      default: load_val = w_q.rdata;
    endcase
  end

  assign misalign = w_q.valid & (w_q.src == SEL_W'(1)) & ~aligned;

  always_comb begin
    result_w = '0;
    if (!misalign) begin
      case (int'(w_q.src))
        0:       result_w = w_q.alu;
        1:       result_w = load_val;
        2:       result_w = w_q.pc4;
        3:       result_w = (NUM_SRC > 3) ? w_q.imm : '0;
        default: result_w = '0;
      endcase
    end
  end

  assign valid_w     = w_q.valid;
  assign reg_write_w = w_q.valid & w_q.reg_write & (w_q.rd != 5'd0) & ~misalign;
  assign rd_w        = w_q.rd;
  assign misalign_w  = misalign;
  assign instret     = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: RV32 default build with random traffic,
// plus a 64-bit / 3-source / 8-bit-counter build for the boundary cases.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall_w = 0, flush_w = 0, valid_m = 0, reg_write_m = 0;
  logic [4:0]  rd_m = 0;
  logic [1:0]  result_src_m = 0;
  logic [2:0]  load_type_m = 0;
  logic [1:0]  addr_lsb_m = 0;
  logic [31:0] alu_result_m = 0, read_data_m = 0, pc_plus_4m = 0, imm_ext_m = 0;
  logic        valid_w, reg_write_w, misalign_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [63:0] instret;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .result_src_m(result_src_m), .load_type_m(load_type_m), .addr_lsb_m(addr_lsb_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus_4m(pc_plus_4m),
    .imm_ext_m(imm_ext_m), .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .misalign_w(misalign_w), .instret(instret)
  );

  logic        b_stall = 0, b_flush = 0, b_valid = 0, b_rw = 0;
  logic [4:0]  b_rd = 0;
  logic [1:0]  b_src = 0;
  logic [2:0]  b_lt = 0;
  logic [2:0]  b_lsb = 0;
  logic [63:0] b_alu = 64'h1111, b_rdata = 0, b_pc4 = 64'h2222, b_imm = 0;
  logic        b_valid_w, b_reg_write_w, b_misalign_w;
  logic [4:0]  b_rd_w;
  logic [63:0] b_result_w;
  logic [7:0]  b_instret;

  writeback_stage #(.XLEN(64), .NUM_SRC(3), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .stall_w(b_stall), .flush_w(b_flush),
    .valid_m(b_valid), .reg_write_m(b_rw), .rd_m(b_rd),
    .result_src_m(b_src), .load_type_m(b_lt), .addr_lsb_m(b_lsb),
    .alu_result_m(b_alu), .read_data_m(b_rdata), .pc_plus_4m(b_pc4),
    .imm_ext_m(b_imm), .valid_w(b_valid_w), .reg_write_w(b_reg_write_w), .rd_w(b_rd_w),
    .result_w(b_result_w), .misalign_w(b_misalign_w), .instret(b_instret)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
    logic        we;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the register file should see for one RV32 instruction.
  function automatic exp_t ref_w(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                                 input logic [2:0] lt, input logic [1:0] lsb,
                                 input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [31:0] pc4, input logic [31:0] imm);
    exp_t        e;
    logic [31:0] sh, ld;
    bit          mis;
    sh  = rdata >> (8 * lsb);
    ld  = rdata;
    mis = 0;
    case (lt)
      3'd0: begin ld = sh & 32'hFF;   if (ld >= 128)   ld = ld - 256;   end
      3'd1: begin ld = sh & 32'hFFFF; if (ld >= 32768) ld = ld - 65536; mis = (lsb % 2) != 0; end
      3'd2: begin ld = rdata; mis = (lsb != 0); end
      3'd4: ld = sh & 32'hFF;
      3'd5: begin ld = sh & 32'hFFFF; mis = (lsb % 2) != 0; end
      default: ld = rdata;
    endcase
    if (src != 2'd1) mis = 0;
    e.rd  = rd;
    e.mis = mis;
    e.res = mis ? 32'd0 : (src == 2'd0) ? alu : (src == 2'd1) ? ld : (src == 2'd2) ? pc4 : imm;
    e.we  = rw && (rd != 0) && !mis;
    return e;
  endfunction

  task automatic issue(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] lt, input logic [1:0] lsb, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic st, input logic fl);
    @(posedge clk);
    #1;
    valid_m = v; reg_write_m = rw; rd_m = rd; result_src_m = src; load_type_m = lt;
    addr_lsb_m = lsb; alu_result_m = alu; read_data_m = rdata; pc_plus_4m = pc4;
    imm_ext_m = imm; stall_w = st; flush_w = fl;
    if (v && !st && !fl) sbq.push_back(ref_w(rw, rd, src, lt, lsb, alu, rdata, pc4, imm));
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic one_load(input logic [2:0] lt, input logic [1:0] lsb,
                          input logic [31:0] exp_res, input logic exp_mis);
    issue(1, 1, 5'd7, 2'd1, lt, lsb, 32'h5555, 32'h8070_F0A5, 32'h44, 32'h66, 0, 0);
    idle();
    @(negedge clk);
    check("load_result", result_w, exp_res);
    check("load_misalign", misalign_w, exp_mis);
    check("load_regwrite", reg_write_w, !exp_mis);
  endtask

  // Monitor: compares whatever W presents against the scoreboard head.
  logic            exp_valid = 0;
  longint unsigned mcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      exp_valid = 0;
      mcnt = 0;
    end else begin
      check("instret", instret, mcnt);
      check("valid_w", valid_w, exp_valid);
      if (exp_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: W valid but no expected entry at %0t", $time);
        end else begin
          check("rd_w", rd_w, sbq[0].rd);
          check("result_w", result_w, sbq[0].res);
          check("misalign_w", misalign_w, sbq[0].mis);
          check("reg_write_w", reg_write_w, sbq[0].we);
        end
      end else begin
        check("bubble_reg_write", reg_write_w, 0);
        check("bubble_misalign", misalign_w, 0);
      end
      if (exp_valid && !stall_w) begin
        mcnt++;
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else if (exp_valid && flush_w) begin
        if (sbq.size() != 0) void'(sbq.pop_front());
      end
      exp_valid = flush_w ? 1'b0 : (stall_w ? exp_valid : valid_m);
    end
  end

  task automatic b_issue(input logic v, input logic [1:0] src, input logic [2:0] lt,
                         input logic [2:0] lsb, input logic [63:0] rdata, input logic [63:0] imm);
    @(posedge clk);
    #1;
    b_valid = v; b_rw = v; b_rd = 5'd3; b_src = src; b_lt = lt; b_lsb = lsb;
    b_rdata = rdata; b_imm = imm;
  endtask

  task automatic b_one(input string name, input logic [1:0] src, input logic [2:0] lt,
                       input logic [2:0] lsb, input logic [63:0] rdata, input logic [63:0] imm,
                       input logic [63:0] exp_res, input logic exp_mis);
    b_issue(1, src, lt, lsb, rdata, imm);
    b_issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check({name, "_result"}, b_result_w, exp_res);
    check({name, "_misalign"}, b_misalign_w, exp_mis);
    check({name, "_regwrite"}, b_reg_write_w, !exp_mis);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_w", valid_w, 0);
    check("rst_reg_write_w", reg_write_w, 0);
    check("rst_rd_w", rd_w, 0);
    check("rst_result_w", result_w, 0);
    check("rst_misalign_w", misalign_w, 0);
    check("rst_instret", instret, 0);
    @(posedge clk);
    #1 rst_n = 1;

    // Plain ALU op
    issue(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0, 0);
    idle();
    @(negedge clk);
    check("alu_result", result_w, 32'h1234);
    check("alu_reg_write", reg_write_w, 1);
    check("alu_rd", rd_w, 5);
    idle();
    @(negedge clk);
    check("alu_instret", instret, 1);

    // Load extraction on 0x8070_F0A5
    one_load(3'd0, 2'd0, 32'hFFFF_FFA5, 0);
    one_load(3'd4, 2'd3, 32'h0000_0080, 0);
    one_load(3'd1, 2'd2, 32'hFFFF_8070, 0);
    one_load(3'd5, 2'd0, 32'h0000_F0A5, 0);
    one_load(3'd1, 2'd1, 32'h0, 1);
    one_load(3'd2, 2'd0, 32'h8070_F0A5, 0);
    for (int lt = 0; lt < 8; lt++)
      for (int l = 0; l < 4; l++)
        issue(1, 1, 5'd9, 2'd1, 3'(lt), 2'(l), 32'h1, 32'h8070_F0A5, 32'h2, 32'h3, 0, 0);
    idle();

    // Stall for 3 cycles while M changes
    issue(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hAAAA_0001, 32'h0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      issue(1, 1, 5'(i + 1), 2'd2, 3'd0, 2'd0, $urandom, $urandom, $urandom, $urandom, 1, 0);
    idle();
    idle();

    // rd=0 write suppressed but counted; then flush+stall on the same edge
    issue(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hBEEF, 32'h0, 32'h0, 32'h0, 0, 0);
    idle();
    @(negedge clk);
    check("x0_valid", valid_w, 1);
    check("x0_reg_write", reg_write_w, 0);
    issue(1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'hC0DE, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(1, 1, 5'd6, 2'd0, 3'd0, 2'd0, 32'hD00D, 32'h0, 32'h0, 32'h0, 1, 1);
    idle();
    @(negedge clk);
    check("flush_valid", valid_w, 0);
    check("flush_reg_write", reg_write_w, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rd,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    idle();
    idle();

    // Async reset mid-stall
    issue(1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h7777, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(1, 1, 5'd13, 2'd0, 3'd0, 2'd0, 32'h8888, 32'h0, 32'h0, 32'h0, 1, 0);
    issue(1, 1, 5'd13, 2'd0, 3'd0, 2'd0, 32'h8888, 32'h0, 32'h0, 32'h0, 1, 0);
    #2;
    check("pre_rst_valid", valid_w, 1);
    rst_n = 0;
    #1;
    check("arst_valid_w", valid_w, 0);
    check("arst_reg_write_w", reg_write_w, 0);
    check("arst_rd_w", rd_w, 0);
    check("arst_result_w", result_w, 0);
    check("arst_instret", instret, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    valid_m = 0; stall_w = 0; flush_w = 0;
    rst_n = 1;
    issue(1, 1, 5'd2, 2'd3, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 0, 0);
    idle();
    idle();
    idle();
    check("sb_drain", sbq.size(), 0);

    // 64-bit, 3-source, 8-bit counter build
    @(negedge clk);
    check("b_instret_start", b_instret, 0);
    for (int k = 1; k <= 258; k++) begin
      b_issue(1, 2'd0, 3'd0, 3'd0, 64'h0, 64'h0);
      @(negedge clk);
      if (k == 257) check("b_instret_max", b_instret, 8'd255);
      if (k == 258) check("b_instret_wrap", b_instret, 8'd0);
    end
    b_one("b_src3", 2'd3, 3'd0, 3'd0, 64'h0, 64'h55, 64'h0, 0);
    b_one("b_src2", 2'd2, 3'd0, 3'd0, 64'h0, 64'h55, 64'h2222, 0);
    b_one("b_lw", 2'd1, 3'd2, 3'd0, 64'h0000_0000_8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 0);
    b_one("b_lwu", 2'd1, 3'd6, 3'd4, 64'h9234_5678_0000_0000, 64'h0, 64'h0000_0000_9234_5678, 0);
    b_one("b_ld", 2'd1, 3'd3, 3'd0, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'hDEAD_BEEF_0123_4567, 0);
    b_one("b_ld_mis", 2'd1, 3'd3, 3'd4, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 1);
    b_one("b_lhu", 2'd1, 3'd5, 3'd6, 64'hA1B2_0000_0000_0000, 64'h0, 64'h0000_0000_0000_A1B2, 0);
    b_one("b_illegal", 2'd1, 3'd7, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
